// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic array edge blocks.
package systolic_pkg;

    localparam int OUT_DATA_WIDTH_DEF = 32;
    localparam int ROW_CNT_W = 16;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head read.
module sync_fifo
    import systolic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int LW = level_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];
    assign level   = cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// South-edge psum collector: de-skews bottom-row psums into aligned rows.
// Optional PSUM_DRAIN_RELU_EN clamps negative columns to zero on FIFO write.
module psum_drain
    import systolic_pkg::*;
#(
    parameter int COLS           = 4,
    parameter int OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [COLS*OUT_DATA_WIDTH-1:0]      in_psum,
    input  logic [ROW_CNT_W-1:0]                num_rows,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [COLS*OUT_DATA_WIDTH-1:0]      out_data,
    output logic                                out_last,
    output logic [level_w(FIFO_DEPTH)-1:0]      fifo_level,
    output logic                                overflow
);

    localparam int W = OUT_DATA_WIDTH;

    logic [COLS*W-1:0]    aligned;
    logic [COLS*W-1:0]    wdata;
    logic                 row_valid;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic [ROW_CNT_W-1:0] row_cnt;

    // Column j lags column 0 by j cycles, so it needs COLS-1-j stages
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*W +: W] = in_psum[j*W +: W];
        end else begin : g_dly
            logic [W-1:0] sr [D];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= in_psum[j*W +: W];
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            end
            assign aligned[j*W +: W] = sr[D-1];
        end
    end

    if (COLS == 1) begin : g_v0
        assign row_valid = in_valid;
    end else begin : g_vp
        logic [COLS-2:0] vp;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vp <= '0;
            end else if (clear) begin
                vp <= '0;
            end else begin
                vp[0] <= in_valid;
                for (int i = 1; i < COLS - 1; i++) vp[i] <= vp[i-1];
            end
        end
        assign row_valid = vp[COLS-2];
    end

    always_comb begin
        wdata = aligned;
`ifdef PSUM_DRAIN_RELU_EN
        for (int j = 0; j < COLS; j++) begin
            if (aligned[j*W + W - 1]) wdata[j*W +: W] = '0;
        end
`else
`endif
    end

    sync_fifo #(
        .WIDTH (COLS*W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .push  (row_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // num_rows of zero disables tile framing; the counter just wraps
    assign out_last  = out_valid && (num_rows != '0) &&
                       (row_cnt == num_rows - 16'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
        end else if (pop) begin
            row_cnt <= out_last ? '0 : row_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (row_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
